// File: rtl/wb_mtimer.sv
// -----------------------------------------------------------------------------
// wb_mtimer -- RISC-V machine timer (mtime / mtimecmp) as a Wishbone slave.
//
// A free-running 64-bit mtime advances once per prescaler period while
// CTRL.EN is set. A level interrupt is raised (registered) when CTRL.IE is
// set and mtime >= mtimecmp (unsigned).
//
// Register map, word index i_wb_addr[4:2]:
//   0 CTRL [0]=EN [1]=IE      1 PRESC reload      2 MTIME_LO     3 MTIME_HI
//   4 MTIMECMP_LO             5 MTIMECMP_HI       6 STATUS [0]=match (RO)
//   7 reserved (reads 0, writes ignored, still acked)
//
// Ports:
//   i_clk, i_reset_n            clock, asynchronous active-low reset
//   i_sel                       slot select from the NIC address decode
//   i_wb_addr/stb/cyc/we/sel    Wishbone request (byte lanes honoured on writes)
//   i_wb_wdata                  write data
//   o_wb_ack                    registered one-cycle acknowledge, no wait states
//   o_wb_rdata                  read data, valid while o_wb_ack=1
//   o_irq                       machine timer interrupt, registered level
//
// Configuration macro WB_MTIMER_SNAPSHOT_EN:
//   defined     -> reading MTIME_LO latches mtime[63:32] into a shadow and
//                  MTIME_HI reads return the shadow (coherent 64-bit read).
//   not defined -> MTIME_HI reads return live mtime[63:32].
// -----------------------------------------------------------------------------
module wb_mtimer #(
    parameter int          PRESC_WIDTH = 16,
    parameter logic [63:0] CMP_RESET   = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_sel,
    input  logic [31:0] i_wb_addr,
    input  logic        i_wb_stb,
    input  logic        i_wb_cyc,
    input  logic        i_wb_we,
    input  logic [3:0]  i_wb_sel,
    input  logic [31:0] i_wb_wdata,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_rdata,
    output logic        o_irq
);

    // Replace the byte lanes selected by sel with the new value.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = sel[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return res;
    endfunction

    logic [1:0]             ctrl_q,      ctrl_d;
    logic [PRESC_WIDTH-1:0] presc_q,     presc_d;
    logic [PRESC_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
    logic [63:0]            mtime_q,     mtime_d;
    logic [63:0]            cmp_q,       cmp_d;
    logic                   ack_q,       ack_d;
    logic [31:0]            rdata_q,     rdata_d;
    logic                   irq_q,       irq_d;
    logic [31:0]            shadow_q,    shadow_d;

    logic        req_s, wr_s, rd_s, any_lane_s;
    logic [2:0]  idx_s;
    logic        tick_s, carry_s, match_s, mtime_wr_s;
    logic [31:0] lo_inc_s, hi_inc_s;
    logic [29:0] unused_addr_s;

    assign unused_addr_s = {i_wb_addr[31:5], i_wb_addr[1:0], 1'b0};

    assign req_s      = i_sel & i_wb_cyc & i_wb_stb & ~ack_q;
    assign wr_s       = req_s & i_wb_we;
    assign rd_s       = req_s & ~i_wb_we;
    assign idx_s      = i_wb_addr[4:2];
    assign any_lane_s = |i_wb_sel;

    // Prescaler tick and split increment of mtime so a half-word write can merge.
    assign tick_s     = ctrl_q[0] & (presc_cnt_q == presc_q);
    assign carry_s    = tick_s & (mtime_q[31:0] == 32'hFFFF_FFFF);
    assign lo_inc_s   = mtime_q[31:0]  + {31'd0, tick_s};
    assign hi_inc_s   = mtime_q[63:32] + {31'd0, carry_s};
    assign mtime_wr_s = wr_s & any_lane_s & ((idx_s == 3'd2) | (idx_s == 3'd3));
    assign match_s    = (mtime_q >= cmp_q);

    // Next-state logic: register writes, counters, read mux, ack and irq.
    always_comb begin
        ctrl_d      = ctrl_q;
        presc_d     = presc_q;
        presc_cnt_d = presc_cnt_q;
        cmp_d       = cmp_q;
        shadow_d    = shadow_q;
        rdata_d     = 32'd0;
        ack_d       = req_s;
        irq_d       = ctrl_q[1] & match_s;

        // Counter advance; a write overrides the written bytes below.
        if (ctrl_q[0]) begin
            if (tick_s) begin
                presc_cnt_d = {PRESC_WIDTH{1'b0}};
            end else begin
                presc_cnt_d = presc_cnt_q + {{(PRESC_WIDTH-1){1'b0}}, 1'b1};
            end
        end else begin
            presc_cnt_d = presc_cnt_q;
        end

        // During an mtime write the LO->HI carry is suppressed.
        mtime_d[31:0]  = lo_inc_s;
        mtime_d[63:32] = mtime_wr_s ? mtime_q[63:32] : hi_inc_s;

        if (wr_s) begin
            case (idx_s)
                3'd0: begin
                    if (i_wb_sel[0]) begin
                        ctrl_d = i_wb_wdata[1:0];
                    end else begin
                        ctrl_d = ctrl_q;
                    end
                end
                3'd1: begin
                    for (int i = 0; i < PRESC_WIDTH; i++) begin
                        presc_d[i] = i_wb_sel[i/8] ? i_wb_wdata[i] : presc_q[i];
                    end
                    if (any_lane_s) begin
                        presc_cnt_d = {PRESC_WIDTH{1'b0}};
                    end else begin
                        presc_cnt_d = presc_cnt_q;
                    end
                end
                3'd2: mtime_d[31:0]  = merge_bytes(lo_inc_s, i_wb_wdata, i_wb_sel);
                3'd3: mtime_d[63:32] = merge_bytes(mtime_q[63:32], i_wb_wdata, i_wb_sel);
                3'd4: cmp_d[31:0]    = merge_bytes(cmp_q[31:0], i_wb_wdata, i_wb_sel);
                3'd5: cmp_d[63:32]   = merge_bytes(cmp_q[63:32], i_wb_wdata, i_wb_sel);
                default: ;
            endcase
        end else begin
            ctrl_d = ctrl_q;
        end

        // Read data comes from pre-write register values of the request cycle.
        if (rd_s) begin
            case (idx_s)
                3'd0: rdata_d = {30'd0, ctrl_q};
                3'd1: rdata_d = {{(32-PRESC_WIDTH){1'b0}}, presc_q};
                3'd2: begin
                    rdata_d = mtime_q[31:0];
`ifdef WB_MTIMER_SNAPSHOT_EN
                    shadow_d = mtime_q[63:32];
`endif
                end
`ifdef WB_MTIMER_SNAPSHOT_EN
                3'd3: rdata_d = shadow_q;
`else
                3'd3: rdata_d = mtime_q[63:32];
`endif
                3'd4: rdata_d = cmp_q[31:0];
                3'd5: rdata_d = cmp_q[63:32];
                3'd6: rdata_d = {31'd0, match_s};
                default: rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = 32'd0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ctrl_q      <= 2'd0;
            presc_q     <= {PRESC_WIDTH{1'b0}};
            presc_cnt_q <= {PRESC_WIDTH{1'b0}};
            mtime_q     <= 64'd0;
            cmp_q       <= CMP_RESET;
            ack_q       <= 1'b0;
            rdata_q     <= 32'd0;
            irq_q       <= 1'b0;
            shadow_q    <= 32'd0;
        end else begin
            ctrl_q      <= ctrl_d;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
            mtime_q     <= mtime_d;
            cmp_q       <= cmp_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            irq_q       <= irq_d;
            shadow_q    <= shadow_d;
        end
    end

    assign o_wb_ack   = ack_q;
    assign o_wb_rdata = rdata_q;
    assign o_irq      = irq_q;

endmodule
